// File: rtl/halt_pkg.sv
// rtl/halt_pkg.sv - shared types and defaults for the run/halt controller
package halt_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DONE_NONE     = 2'd0,
        DONE_OK       = 2'd1,
        DONE_WDOG     = 2'd2,
        DONE_DRAIN_TO = 2'd3
    } done_t;

    localparam int DRAIN_MAX_DEFAULT = 8;

endpackage

// File: rtl/halt_ctrl_if.sv
// rtl/halt_ctrl_if.sv - core-side halt request/retire inputs and halt status outputs
interface halt_ctrl_if #(
    parameter int CYCLE_W = 16
);
    import halt_pkg::*;

    logic               halt_req;
    logic               retire;
    logic               busy;
    logic               freeze;
    logic               halt;
    done_t              done_code;
    logic [CYCLE_W-1:0] cycles;
    logic [CYCLE_W-1:0] retired;

    modport master (
        output halt_req, retire, busy,
        input  freeze, halt, done_code, cycles, retired
    );

    modport slave (
        input  halt_req, retire, busy,
        output freeze, halt, done_code, cycles, retired
    );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - enabled up-counter that sticks at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/halt_ctrl.sv
// rtl/halt_ctrl.sv - run/drain/halt FSM with cycle and retire counters
// Optional cycle watchdog compiled in with HALT_CTRL_WATCHDOG_EN.
module halt_ctrl
    import halt_pkg::*;
#(
    parameter int CYCLE_W     = 16,
    parameter int CYCLE_LIMIT = 30000,
    parameter int DRAIN_MAX   = DRAIN_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    halt_ctrl_if.slave  bus
);

    localparam int DRAIN_W = (DRAIN_MAX > 2) ? $clog2(DRAIN_MAX) : 1;

    state_t             state, state_nx;
    done_t              done_q, done_nx;
    logic [DRAIN_W-1:0] drain_cnt, drain_nx;
    logic [CYCLE_W-1:0] cycles;
    logic [CYCLE_W-1:0] retired;
    logic               cnt_en;

    // Counters run through the edge that enters HALTED, then freeze.
    assign cnt_en = (state != HALTED);

    sat_counter #(.W(CYCLE_W)) u_cycles (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cnt_en),
        .q     (cycles)
    );

    sat_counter #(.W(CYCLE_W)) u_retired (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cnt_en && bus.retire),
        .q     (retired)
    );

`ifdef HALT_CTRL_WATCHDOG_EN
    // Compare at 32+ bits so a narrow counter never aliases onto the limit.
    localparam int CMP_W = (CYCLE_W > 32) ? CYCLE_W : 32;
    logic [CMP_W-1:0] cycles_ext;
    logic             wdog_hit;
    assign cycles_ext = CMP_W'(cycles);
    assign wdog_hit   = (cycles_ext == CMP_W'(CYCLE_LIMIT - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            done_q    <= DONE_NONE;
            drain_cnt <= '0;
        end else begin
            state     <= state_nx;
            done_q    <= done_nx;
            drain_cnt <= drain_nx;
        end
    end

    always_comb begin
        state_nx = state;
        done_nx  = done_q;
        drain_nx = drain_cnt;
        case (state)
            RUN: begin
                if (bus.halt_req) begin
                    state_nx = DRAIN;
                    drain_nx = '0;
                end
`ifdef HALT_CTRL_WATCHDOG_EN
                else if (wdog_hit) begin
                    state_nx = HALTED;
                    done_nx  = DONE_WDOG;
                end
`endif
            end
            DRAIN: begin
                if (!bus.busy) begin
                    state_nx = HALTED;
                    done_nx  = DONE_OK;
                end else if (drain_cnt == DRAIN_W'(DRAIN_MAX - 1)) begin
                    state_nx = HALTED;
                    done_nx  = DONE_DRAIN_TO;
                end else begin
                    drain_nx = drain_cnt + 1'b1;
                end
            end
            HALTED: begin
                state_nx = HALTED;
            end
            default: begin
                state_nx = RUN;
            end
        endcase
    end

    assign bus.freeze    = (state != RUN);
    assign bus.halt      = (state == HALTED);
    assign bus.done_code = done_q;
    assign bus.cycles    = cycles;
    assign bus.retired   = retired;

endmodule

// File: tb/tb_halt_ctrl.sv
// tb/tb_halt_ctrl.sv - directed self-checking bench for halt_ctrl
module tb_halt_ctrl;
    import halt_pkg::*;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    halt_ctrl_if #(.CYCLE_W(16)) bus ();
    halt_ctrl_if #(.CYCLE_W(4))  bus4 ();

    halt_ctrl #(.CYCLE_W(16), .CYCLE_LIMIT(50), .DRAIN_MAX(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    halt_ctrl #(.CYCLE_W(4), .CYCLE_LIMIT(30000), .DRAIN_MAX(8)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.halt_req  = 1'b0;
        bus.retire    = 1'b0;
        bus.busy      = 1'b0;
        bus4.halt_req = 1'b0;
        bus4.retire   = 1'b0;
        bus4.busy     = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if (bus.halt !== 1'b0) $display("FAIL reset_halt: got %0b want 0", bus.halt); else pass_cnt++;
        total_cnt++;
        if (bus.freeze !== 1'b0) $display("FAIL reset_freeze: got %0b want 0", bus.freeze); else pass_cnt++;
        total_cnt++;
        if (bus.done_code !== 2'd0) $display("FAIL reset_done: got %0d want 0", bus.done_code); else pass_cnt++;
        total_cnt++;
        if (bus.cycles !== 16'd0) $display("FAIL reset_cycles: got %0d want 0", bus.cycles); else pass_cnt++;
        total_cnt++;
        if (bus.retired !== 16'd0) $display("FAIL reset_retired: got %0d want 0", bus.retired); else pass_cnt++;
    endtask

    task automatic test_normal_halt();
        do_reset();
        bus.retire = 1'b1;
        step(10);
        bus.retire   = 1'b0;
        bus.halt_req = 1'b1;
        bus.busy     = 1'b0;
        step(1);
        bus.halt_req = 1'b0;
        total_cnt++;
        if (bus.freeze !== 1'b1) $display("FAIL normal_freeze: got %0b want 1", bus.freeze); else pass_cnt++;
        total_cnt++;
        if (bus.halt !== 1'b0) $display("FAIL normal_halt_early: got %0b want 0", bus.halt); else pass_cnt++;
        step(1);
        total_cnt++;
        if (bus.halt !== 1'b1) $display("FAIL normal_halt: got %0b want 1", bus.halt); else pass_cnt++;
        total_cnt++;
        if (bus.done_code !== 2'd1) $display("FAIL normal_done: got %0d want 1", bus.done_code); else pass_cnt++;
        total_cnt++;
        if (bus.retired !== 16'd10) $display("FAIL normal_retired: got %0d want 10", bus.retired); else pass_cnt++;
        total_cnt++;
        if (bus.cycles !== 16'd12) $display("FAIL normal_cycles: got %0d want 12", bus.cycles); else pass_cnt++;
        // Inputs must be ignored once halted.
        bus.retire   = 1'b1;
        bus.halt_req = 1'b1;
        bus.busy     = 1'b1;
        step(3);
        total_cnt++;
        if (bus.retired !== 16'd10) $display("FAIL halted_retired_frozen: got %0d want 10", bus.retired); else pass_cnt++;
        total_cnt++;
        if (bus.cycles !== 16'd12) $display("FAIL halted_cycles_frozen: got %0d want 12", bus.cycles); else pass_cnt++;
        total_cnt++;
        if (bus.halt !== 1'b1 || bus.done_code !== 2'd1)
            $display("FAIL halted_sticky: got halt=%0b done=%0d want halt=1 done=1", bus.halt, bus.done_code);
        else pass_cnt++;
    endtask

    task automatic test_retire_coincide();
        do_reset();
        bus.retire   = 1'b1;
        bus.halt_req = 1'b1;
        step(1);
        bus.halt_req = 1'b0;
        total_cnt++;
        if (bus.retired !== 16'd1) $display("FAIL coincide_req_retired: got %0d want 1", bus.retired); else pass_cnt++;
        step(1);
        bus.retire = 1'b0;
        total_cnt++;
        if (bus.retired !== 16'd2) $display("FAIL coincide_halt_retired: got %0d want 2", bus.retired); else pass_cnt++;
        total_cnt++;
        if (bus.halt !== 1'b1) $display("FAIL coincide_halt: got %0b want 1", bus.halt); else pass_cnt++;
    endtask

    task automatic test_drain_wait();
        do_reset();
        step(2);
        bus.halt_req = 1'b1;
        bus.busy     = 1'b1;
        step(1);
        bus.halt_req = 1'b0;
        total_cnt++;
        if (bus.freeze !== 1'b1 || bus.halt !== 1'b0)
            $display("FAIL drain_enter: got freeze=%0b halt=%0b want freeze=1 halt=0", bus.freeze, bus.halt);
        else pass_cnt++;
        step(2);
        total_cnt++;
        if (bus.halt !== 1'b0) $display("FAIL drain_wait_halt: got %0b want 0", bus.halt); else pass_cnt++;
        total_cnt++;
        if (bus.cycles !== 16'd5) $display("FAIL drain_cycles_run: got %0d want 5", bus.cycles); else pass_cnt++;
        bus.busy = 1'b0;
        step(1);
        total_cnt++;
        if (bus.halt !== 1'b1) $display("FAIL drain_done_halt: got %0b want 1", bus.halt); else pass_cnt++;
        total_cnt++;
        if (bus.done_code !== 2'd1) $display("FAIL drain_done_code: got %0d want 1", bus.done_code); else pass_cnt++;
        total_cnt++;
        if (bus.cycles !== 16'd6) $display("FAIL drain_done_cycles: got %0d want 6", bus.cycles); else pass_cnt++;
    endtask

    task automatic test_drain_timeout();
        do_reset();
        bus.halt_req = 1'b1;
        bus.busy     = 1'b1;
        step(1);
        bus.halt_req = 1'b0;
        step(2);
        // A repeated request during DRAIN must not restart the timeout.
        bus.halt_req = 1'b1;
        step(1);
        bus.halt_req = 1'b0;
        step(4);
        total_cnt++;
        if (bus.halt !== 1'b0 || bus.freeze !== 1'b1)
            $display("FAIL timeout_early: got halt=%0b freeze=%0b want halt=0 freeze=1", bus.halt, bus.freeze);
        else pass_cnt++;
        step(1);
        total_cnt++;
        if (bus.halt !== 1'b1) $display("FAIL timeout_halt: got %0b want 1", bus.halt); else pass_cnt++;
        total_cnt++;
        if (bus.done_code !== 2'd3) $display("FAIL timeout_done: got %0d want 3", bus.done_code); else pass_cnt++;
        total_cnt++;
        if (bus.cycles !== 16'd9) $display("FAIL timeout_cycles: got %0d want 9", bus.cycles); else pass_cnt++;
        bus.busy = 1'b0;
        step(2);
        total_cnt++;
        if (bus.done_code !== 2'd3) $display("FAIL timeout_done_stable: got %0d want 3", bus.done_code); else pass_cnt++;
    endtask

`ifdef HALT_CTRL_WATCHDOG_EN
    task automatic test_watchdog();
        do_reset();
        step(49);
        total_cnt++;
        if (bus.cycles !== 16'd49 || bus.halt !== 1'b0)
            $display("FAIL wdog_pre: got cycles=%0d halt=%0b want cycles=49 halt=0", bus.cycles, bus.halt);
        else pass_cnt++;
        step(1);
        total_cnt++;
        if (bus.halt !== 1'b1 || bus.done_code !== 2'd2)
            $display("FAIL wdog_halt: got halt=%0b done=%0d want halt=1 done=2", bus.halt, bus.done_code);
        else pass_cnt++;
        step(3);
        total_cnt++;
        if (bus.cycles !== 16'd50) $display("FAIL wdog_cycles_frozen: got %0d want 50", bus.cycles); else pass_cnt++;

        do_reset();
        step(49);
        bus.halt_req = 1'b1;
        step(1);
        bus.halt_req = 1'b0;
        total_cnt++;
        if (bus.freeze !== 1'b1 || bus.halt !== 1'b0)
            $display("FAIL wdog_race_drain: got freeze=%0b halt=%0b want freeze=1 halt=0", bus.freeze, bus.halt);
        else pass_cnt++;
        step(1);
        total_cnt++;
        if (bus.halt !== 1'b1 || bus.done_code !== 2'd1)
            $display("FAIL wdog_race_done: got halt=%0b done=%0d want halt=1 done=1", bus.halt, bus.done_code);
        else pass_cnt++;
    endtask
`endif

    task automatic test_reset_mid_drain();
        do_reset();
        bus.retire = 1'b1;
        step(3);
        bus.retire   = 1'b0;
        bus.halt_req = 1'b1;
        bus.busy     = 1'b1;
        step(1);
        bus.halt_req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (bus.freeze !== 1'b0 || bus.halt !== 1'b0 || bus.done_code !== 2'd0)
            $display("FAIL mid_reset_flags: got freeze=%0b halt=%0b done=%0d want 0 0 0",
                     bus.freeze, bus.halt, bus.done_code);
        else pass_cnt++;
        total_cnt++;
        if (bus.cycles !== 16'd0 || bus.retired !== 16'd0)
            $display("FAIL mid_reset_counts: got cycles=%0d retired=%0d want 0 0", bus.cycles, bus.retired);
        else pass_cnt++;
        bus.busy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(3);
        total_cnt++;
        if (bus.cycles !== 16'd3 || bus.freeze !== 1'b0 || bus.retired !== 16'd0)
            $display("FAIL mid_reset_resume: got cycles=%0d freeze=%0b retired=%0d want 3 0 0",
                     bus.cycles, bus.freeze, bus.retired);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        do_reset();
        bus4.retire = 1'b1;
        step(14);
        total_cnt++;
        if (bus4.cycles !== 4'd14) $display("FAIL sat_pre: got %0d want 14", bus4.cycles); else pass_cnt++;
        step(1);
        total_cnt++;
        if (bus4.cycles !== 4'd15 || bus4.retired !== 4'd15)
            $display("FAIL sat_reach: got cycles=%0d retired=%0d want 15 15", bus4.cycles, bus4.retired);
        else pass_cnt++;
        step(5);
        total_cnt++;
        if (bus4.cycles !== 4'd15 || bus4.retired !== 4'd15)
            $display("FAIL sat_hold: got cycles=%0d retired=%0d want 15 15", bus4.cycles, bus4.retired);
        else pass_cnt++;
        total_cnt++;
        if (bus4.halt !== 1'b0) $display("FAIL sat_no_halt: got %0b want 0", bus4.halt); else pass_cnt++;
        bus4.retire = 1'b0;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_normal_halt();
        test_retire_coincide();
        test_drain_wait();
        test_drain_timeout();
`ifdef HALT_CTRL_WATCHDOG_EN
        test_watchdog();
`endif
        test_reset_mid_drain();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
